// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: sizes, state
// encoding and the default grant-hold limit.
package rr_arbiter8_pkg;

  localparam int NREQ            = 8;
  localparam int IDX_W           = 3;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The timeout pulse exists only when RR_ARB_TIMEOUT_EN is defined.
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  logic [NREQ-1:0]  req;
  logic             done;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [NREQ-1:0]  gnt;
`ifdef RR_ARB_TIMEOUT_EN
  logic             timeout;

  modport master (output req, output done,
                  input gnt_valid, input gnt_idx, input gnt, input timeout);
  modport slave  (input req, input done,
                  output gnt_valid, output gnt_idx, output gnt, output timeout);
`else
  modport master (output req, output done,
                  input gnt_valid, input gnt_idx, input gnt);
  modport slave  (input req, input done,
                  output gnt_valid, output gnt_idx, output gnt);
`endif

endinterface

// File: rtl/rr_arbiter8_decoder.sv
// 3-to-8 decoder with enable; all outputs low while E is low.
module Decoder3_8 (
  input  logic       E,
  input  logic [2:0] w,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (E) y[w] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter: grant held until done or request drop.
// Define RR_ARB_TIMEOUT_EN to revoke grants held longer than TIMEOUT cycles.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
)
`endif
(
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter8_if.slave bus
);

  state_t           r_state, w_next_state;
  logic [IDX_W-1:0] r_idx, r_last;
  logic [IDX_W-1:0] w_win, w_pos;
  logic [IDX_W:0]   w_shift;
  logic [NREQ-1:0]  w_rot, w_gnt;
  logic             w_load, w_rel, w_revoke;
`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0]       r_cnt;
  logic             r_timeout;
  logic             w_to_hit;
`endif

  // Rotate so the slot after the last winner sits at bit 0, then take the lowest set bit.
  always_comb begin
    w_shift = {1'b0, r_last} + 4'd1;
    w_rot   = (bus.req >> w_shift) | (bus.req << (4'd8 - w_shift));
    w_pos   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = IDX_W'(i);
    end
    w_win = r_last + 3'd1 + w_pos;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_rel        = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    w_to_hit     = (r_state == GRANT) && (r_cnt == 8'(TIMEOUT - 1));
`endif
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_next_state = GRANT;
          w_load       = 1'b1;
        end
      end
      GRANT: begin
        w_rel = bus.done || !bus.req[r_idx];
      end
    endcase
`ifdef RR_ARB_TIMEOUT_EN
    w_revoke = w_rel || w_to_hit;
`else
    w_revoke = w_rel;
`endif
    if (r_state == GRANT && w_revoke) w_next_state = IDLE;
  end

  // The pointer moves only when a new winner is loaded, never on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_last  <= IDX_W'(NREQ - 1);
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_idx  <= w_win;
        r_last <= w_win;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // A normal release in the same cycle as the limit takes precedence over timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_load) r_cnt <= '0;
      else if (r_state == GRANT) r_cnt <= r_cnt + 8'd1;
      r_timeout <= w_to_hit && !w_rel;
    end
  end

  assign bus.timeout = r_timeout;
`endif

  Decoder3_8 u_dec (
    .E (bus.gnt_valid),
    .w (r_idx),
    .y (w_gnt)
  );

  assign bus.gnt_valid = (r_state == GRANT);
  assign bus.gnt_idx   = r_idx;
  assign bus.gnt       = w_gnt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed table-driven bench for rr_arbiter8, plus hand-written
// sequences for asynchronous reset and the optional timeout.
module tb_rr_arbiter8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  rr_arbiter8_if bus ();

`ifdef RR_ARB_TIMEOUT_EN
  rr_arbiter8 #(.TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  rr_arbiter8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       vld;
    logic [2:0] idx;
    logic [7:0] gnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] rq, input logic d,
                     input logic v, input logic [2:0] ix, input logic [7:0] g);
    vec_t e;
    e.rst = r; e.req = rq; e.done = d; e.vld = v; e.idx = ix; e.gnt = g;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [2:0] ix,
                         input logic [7:0] g);
    chk({nm, ".gnt_valid"}, {7'd0, bus.gnt_valid}, {7'd0, v});
    chk({nm, ".gnt_idx"},   {5'd0, bus.gnt_idx},   {5'd0, ix});
    chk({nm, ".gnt"},       bus.gnt,               g);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    #2;
    chk_out("reset", 1'b0, 3'd0, 8'h00);
`ifdef RR_ARB_TIMEOUT_EN
    chk("reset.timeout", {7'd0, bus.timeout}, 8'h00);
`endif

    // single requester, release by done
    add(1, 8'h01, 0, 1, 3'd0, 8'h01);
    add(0, 8'h01, 1, 0, 3'd0, 8'h00);
    add(0, 8'h00, 0, 0, 3'd0, 8'h00);
    // all requesting, done held high: done in IDLE is ignored
    for (int k = 0; k <= 8; k++) begin
      add(k == 0, 8'hFF, 1, 1, 3'(k % 8), 8'h01 << (k % 8));
      add(0,      8'hFF, 1, 0, 3'(k % 8), 8'h00);
    end
    // owner 3 with 7 waiting: no preemption, drop releases, wrap back to 3
    add(1, 8'h08, 0, 1, 3'd3, 8'h08);
    add(0, 8'h88, 0, 1, 3'd3, 8'h08);
    add(0, 8'h80, 0, 0, 3'd3, 8'h00);
    add(0, 8'h88, 0, 1, 3'd7, 8'h80);
    add(0, 8'h88, 1, 0, 3'd7, 8'h00);
    add(0, 8'h88, 0, 1, 3'd3, 8'h08);
    // done and request drop together: pointer advances once
    add(1, 8'h08, 0, 1, 3'd3, 8'h08);
    add(0, 8'h10, 1, 0, 3'd3, 8'h00);
    add(0, 8'h18, 0, 1, 3'd4, 8'h10);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      bus.req  = tbl[i].req;
      bus.done = tbl[i].done;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].vld, tbl[i].idx, tbl[i].gnt);
    end

    // asynchronous reset mid-grant; pointer returns to 7
    do_reset();
    bus.req = 8'h04;
    step();
    chk_out("pre_arst", 1'b1, 3'd2, 8'h04);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("arst_now", 1'b0, 3'd0, 8'h00);
    bus.req = 8'h81;
    #2;
    rst_n = 1'b1;
    step();
    chk_out("arst_resume", 1'b1, 3'd0, 8'h01);
    bus.req = 8'h80;
    #4;
    rst_n = 1'b0;
    #1;
    chk_out("arst2_now", 1'b0, 3'd0, 8'h00);
    #2;
    rst_n = 1'b1;
    step();
    chk_out("arst2_resume", 1'b1, 3'd7, 8'h80);

`ifdef RR_ARB_TIMEOUT_EN
    do_reset();
    bus.req = 8'h02;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_out($sformatf("to_hold%0d", c), 1'b1, 3'd1, 8'h02);
      chk($sformatf("to_hold%0d.timeout", c), {7'd0, bus.timeout}, 8'h00);
    end
    step();
    chk_out("to_revoke", 1'b0, 3'd1, 8'h00);
    chk("to_revoke.timeout", {7'd0, bus.timeout}, 8'h01);
    step();
    chk_out("to_regrant", 1'b1, 3'd1, 8'h02);
    chk("to_regrant.timeout", {7'd0, bus.timeout}, 8'h00);
    // done on the limit cycle is a normal release
    step();
    step();
    step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk_out("to_done", 1'b0, 3'd1, 8'h00);
    chk("to_done.timeout", {7'd0, bus.timeout}, 8'h00);
`else
    do_reset();
    bus.req = 8'h02;
    for (int c = 0; c < 20; c++) begin
      step();
      chk_out($sformatf("hold%0d", c), 1'b1, 3'd1, 8'h02);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
